seq_multiplier_n: RTL and testbench

Parametrised sequential shift-add multiplier; next generation of the hardwired 4x4 multiplier2 datapath.
- Operands M (multiplicand) and Q (multiplier) are port inputs latched on start.
- One add/shift iteration per clock; 2N-bit product on AQ, with a ready/done handshake.
- Sits between the operand source (switches or a host FSM) and the display/result consumer.

---
 rtl/seq_mult_pkg.sv | 16 +
 rtl/seq_multiplier_n_addsub.sv | 32 +++
 rtl/seq_multiplier_n.sv | 119 +++++++++++
 tb/tb_seq_multiplier_n.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_mult_pkg.sv
// rtl/seq_mult_pkg.sv - shared state type and parameter limits for seq_multiplier_n
package seq_mult_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam int MIN_N = 2;
   localparam int MAX_N = 32;

   function automatic bit n_is_legal(input int n);
      return (n >= MIN_N) && (n <= MAX_N);
   endfunction

endpackage

// File: rtl/seq_multiplier_n_addsub.sv
// rtl/seq_multiplier_n_addsub.sv - N+1-bit adder/subtractor (addsub_n); SIGNED_MULT_EN adds sign extension and subtract
module addsub_n #(
   parameter int N = 4
) (
   input  logic [N-1:0] i_a,
   input  logic [N-1:0] i_m,
   input  logic         i_sub,
   output logic [N-1:0] o_sum,
   output logic         o_cout
);

   logic [N:0] w_a_ext;
   logic [N:0] w_m_ext;
   logic [N:0] w_res;

`ifdef SIGNED_MULT_EN
   // Bit N is the true sign of the sum and becomes the arithmetic-shift fill.
   assign w_a_ext = {i_a[N-1], i_a};
   assign w_m_ext = {i_m[N-1], i_m};
   assign w_res   = i_sub ? (w_a_ext - w_m_ext) : (w_a_ext + w_m_ext);
`else
   logic w_unused_sub;
   assign w_unused_sub = i_sub;
   assign w_a_ext      = {1'b0, i_a};
   assign w_m_ext      = {1'b0, i_m};
   assign w_res        = w_a_ext + w_m_ext;
`endif

   assign o_sum  = w_res[N-1:0];
   assign o_cout = w_res[N];

endmodule

// File: rtl/seq_multiplier_n.sv
// rtl/seq_multiplier_n.sv - N-bit sequential shift-add multiplier with ready/busy/done handshake
// Optional two's-complement operation under macro SIGNED_MULT_EN.
module seq_multiplier_n #(
   parameter int N = 4
) (
   input  logic           clock,
   input  logic           reset,
   input  logic           start,
   input  logic [N-1:0]   M,
   input  logic [N-1:0]   Q,
   output logic           ready,
   output logic           busy,
   output logic           done,
   output logic [2*N-1:0] AQ
);

   import seq_mult_pkg::*;

   localparam int CW = $clog2(N + 1);

   if (!n_is_legal(N)) begin : g_bad_n
      $error("seq_multiplier_n: N must be within 2..32");
   end

   state_t        r_state;
   state_t        w_state_nxt;
   logic [N-1:0]  r_mreg;
   logic [N-1:0]  r_a;
   logic [N-1:0]  r_q;
   logic [CW-1:0] r_count;
   logic          r_done;

   logic          w_load;
   logic          w_step;
   logic          w_last;
   logic          w_sub;
   logic [N-1:0]  w_addend;
   logic [N-1:0]  w_sum;
   logic          w_c;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_step      = 1'b0;
      w_last      = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_load      = 1'b1;
               w_state_nxt = RUN;
            end
         end
         RUN: begin
            w_step = 1'b1;
            if (r_count == CW'(1)) begin
               w_last      = 1'b1;
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // A zero addend when Q0=0 makes {C,A} simply the (sign-)extended A.
   assign w_addend = r_q[0] ? r_mreg : '0;

`ifdef SIGNED_MULT_EN
   assign w_sub = w_last & r_q[0];
`else
   assign w_sub = 1'b0;
`endif

   addsub_n #(
      .N (N)
   ) u_addsub (
      .i_a    (r_a),
      .i_m    (w_addend),
      .i_sub  (w_sub),
      .o_sum  (w_sum),
      .o_cout (w_c)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_mreg  <= '0;
         r_a     <= '0;
         r_q     <= '0;
         r_count <= '0;
         r_done  <= 1'b0;
      end else begin
         r_done <= w_last;
         if (w_load) begin
            r_mreg  <= M;
            r_a     <= '0;
            r_q     <= Q;
            r_count <= CW'(N);
         end else if (w_step) begin
            // {C,A,Q} >> 1 with C entering the MSB; C is consumed and implicitly cleared.
            r_a     <= {w_c, w_sum[N-1:1]};
            r_q     <= {w_sum[0], r_q[N-1:1]};
            r_count <= r_count - CW'(1);
         end
      end
   end

   assign ready = (r_state == IDLE);
   assign busy  = (r_state == RUN);
   assign done  = r_done;
   assign AQ    = {r_a, r_q};

endmodule

// File: tb/tb_seq_multiplier_n.sv
// tb/tb_seq_multiplier_n.sv - directed self-checking bench for seq_multiplier_n (N=4 and N=8 instances)
module tb_seq_multiplier_n;

   logic        clk;
   logic        rst;
   logic        start4;
   logic [3:0]  m4;
   logic [3:0]  q4;
   logic        ready4;
   logic        busy4;
   logic        done4;
   logic [7:0]  aq4;
   logic        start8;
   logic [7:0]  m8;
   logic [7:0]  q8;
   logic        ready8;
   logic        busy8;
   logic        done8;
   logic [15:0] aq8;

   int checks;
   int errors;

   seq_multiplier_n #(.N(4)) u_dut4 (
      .clock (clk),
      .reset (rst),
      .start (start4),
      .M     (m4),
      .Q     (q4),
      .ready (ready4),
      .busy  (busy4),
      .done  (done4),
      .AQ    (aq4)
   );

   seq_multiplier_n #(.N(8)) u_dut8 (
      .clock (clk),
      .reset (rst),
      .start (start8),
      .M     (m8),
      .Q     (q8),
      .ready (ready8),
      .busy  (busy8),
      .done  (done8),
      .AQ    (aq8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Pulses start for one edge, then waits (bounded) for done; lat = edges from acceptance to done.
   task automatic run4(input logic [3:0] m, input logic [3:0] q, output int lat, output bit tmo);
      m4 = m;
      q4 = q;
      start4 = 1'b1;
      tick();
      start4 = 1'b0;
      lat = 0;
      while (!done4 && lat < 20) begin
         tick();
         lat++;
      end
      tmo = !done4;
   endtask

   task automatic run8(input logic [7:0] m, input logic [7:0] q, output int lat, output bit tmo);
      m8 = m;
      q8 = q;
      start8 = 1'b1;
      tick();
      start8 = 1'b0;
      lat = 0;
      while (!done8 && lat < 30) begin
         tick();
         lat++;
      end
      tmo = !done8;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      checks++;
      if ({ready4, busy4, done4, aq4} !== {1'b1, 1'b0, 1'b0, 8'h00}) begin
         errors++;
         $display("FAIL reset_state got rdy=%b busy=%b done=%b aq=%h exp 1 0 0 00", ready4, busy4, done4, aq4);
      end
      checks++;
      if ({ready8, busy8, done8, aq8} !== {1'b1, 1'b0, 1'b0, 16'h0000}) begin
         errors++;
         $display("FAIL reset_state8 got rdy=%b busy=%b done=%b aq=%h exp 1 0 0 0000", ready8, busy8, done8, aq8);
      end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_basic();
      int lat;
      m4 = 4'd5;
      q4 = 4'd7;
      start4 = 1'b1;
      tick();
      start4 = 1'b0;
      checks++;
      if ({busy4, ready4, aq4} !== {1'b1, 1'b0, 8'h07}) begin
         errors++;
         $display("FAIL basic_load got busy=%b rdy=%b aq=%h exp 1 0 07", busy4, ready4, aq4);
      end
      lat = 0;
      while (!done4 && lat < 20) begin
         checks++;
         if (busy4 !== 1'b1) begin
            errors++;
            $display("FAIL basic_busy got %b exp 1 at cycle %0d", busy4, lat);
         end
         tick();
         lat++;
      end
      checks++;
      if (lat !== 4) begin
         errors++;
         $display("FAIL basic_latency got %0d exp 4", lat);
      end
      checks++;
      if ({aq4, ready4, busy4} !== {8'h23, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL basic_result got aq=%h rdy=%b busy=%b exp 23 1 0", aq4, ready4, busy4);
      end
      tick();
      checks++;
      if ({done4, aq4} !== {1'b0, 8'h23}) begin
         errors++;
         $display("FAIL basic_hold got done=%b aq=%h exp 0 23", done4, aq4);
      end
   endtask

   task automatic test_extremes();
      int lat;
      bit tmo;
      run4(4'd15, 4'd15, lat, tmo);
      checks++;
      if ({tmo, aq4} !== {1'b0, 8'hE1} || lat != 4) begin
         errors++;
         $display("FAIL max_operands got aq=%h lat=%0d tmo=%b exp E1 4 0", aq4, lat, tmo);
      end
      tick();
      run4(4'd9, 4'd0, lat, tmo);
      checks++;
      if ({tmo, aq4} !== {1'b0, 8'h00} || lat != 4) begin
         errors++;
         $display("FAIL zero_multiplier got aq=%h lat=%0d tmo=%b exp 00 4 0", aq4, lat, tmo);
      end
      tick();
   endtask

   task automatic test_ignore_start();
      int lat;
      m4 = 4'd6;
      q4 = 4'd3;
      start4 = 1'b1;
      tick();
      m4 = 4'd15;
      q4 = 4'd15;
      tick();
      tick();
      start4 = 1'b0;
      lat = 2;
      while (!done4 && lat < 20) begin
         tick();
         lat++;
      end
      checks++;
      if (aq4 !== 8'h12 || lat != 4) begin
         errors++;
         $display("FAIL ignore_start got aq=%h lat=%0d exp 12 4", aq4, lat);
      end
      tick();
      checks++;
      if ({busy4, ready4} !== 2'b01) begin
         errors++;
         $display("FAIL ignore_start_idle got busy=%b rdy=%b exp 0 1", busy4, ready4);
      end
   endtask

   task automatic test_back_to_back();
      int lat;
      int gap;
      m4 = 4'd5;
      q4 = 4'd3;
      start4 = 1'b1;
      tick();
      lat = 0;
      while (!done4 && lat < 20) begin
         tick();
         lat++;
      end
      checks++;
      if (aq4 !== 8'h0F || lat != 4 || ready4 !== 1'b1) begin
         errors++;
         $display("FAIL b2b_first got aq=%h lat=%0d rdy=%b exp 0F 4 1", aq4, lat, ready4);
      end
      m4 = 4'd2;
      q4 = 4'd7;
      gap = 0;
      do begin
         tick();
         gap++;
      end while (!done4 && gap < 20);
      start4 = 1'b0;
      checks++;
      if (aq4 !== 8'h0E || gap != 5) begin
         errors++;
         $display("FAIL b2b_second got aq=%h gap=%0d exp 0E 5", aq4, gap);
      end
      tick();
      checks++;
      if ({busy4, done4} !== 2'b00) begin
         errors++;
         $display("FAIL b2b_stop got busy=%b done=%b exp 0 0", busy4, done4);
      end
   endtask

   task automatic test_reset_mid();
      int lat;
      int seen;
      bit tmo;
      m4 = 4'd6;
      q4 = 4'd5;
      start4 = 1'b1;
      tick();
      start4 = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      #1;
      checks++;
      if ({ready4, busy4, done4, aq4} !== {1'b1, 1'b0, 1'b0, 8'h00}) begin
         errors++;
         $display("FAIL reset_mid got rdy=%b busy=%b done=%b aq=%h exp 1 0 0 00", ready4, busy4, done4, aq4);
      end
      #2;
      rst = 1'b0;
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (done4) seen++;
      end
      checks++;
      if (seen != 0) begin
         errors++;
         $display("FAIL reset_mid_no_done got %0d done pulses exp 0", seen);
      end
      run4(4'd3, 4'd3, lat, tmo);
      checks++;
      if ({tmo, aq4} !== {1'b0, 8'h09} || lat != 4) begin
         errors++;
         $display("FAIL reset_mid_restart got aq=%h lat=%0d tmo=%b exp 09 4 0", aq4, lat, tmo);
      end
      tick();
   endtask

   task automatic test_wide();
      int lat;
      bit tmo;
      logic [7:0]         rm;
      logic [7:0]         rq;
      logic [15:0]        exp_p;
      logic signed [15:0] sm;
      logic signed [15:0] sq;
      int                 bad;
`ifdef SIGNED_MULT_EN
      run8(8'h80, 8'h80, lat, tmo);
      exp_p = 16'h4000;
`else
      run8(8'hFF, 8'hFF, lat, tmo);
      exp_p = 16'hFE01;
`endif
      checks++;
      if ({tmo, aq8} !== {1'b0, exp_p} || lat != 8) begin
         errors++;
         $display("FAIL wide_extreme got aq=%h lat=%0d tmo=%b exp %h 8 0", aq8, lat, tmo, exp_p);
      end
      tick();
      bad = 0;
      for (int i = 0; i < 100; i++) begin
         rm = 8'($urandom_range(0, 255));
         rq = 8'($urandom_range(0, 255));
`ifdef SIGNED_MULT_EN
         sm = {{8{rm[7]}}, rm};
         sq = {{8{rq[7]}}, rq};
         exp_p = 16'(sm * sq);
`else
         sm = 16'(rm);
         sq = 16'(rq);
         exp_p = 16'(sm * sq);
`endif
         run8(rm, rq, lat, tmo);
         checks++;
         if (tmo || aq8 !== exp_p) begin
            errors++;
            bad++;
            if (bad <= 5)
               $display("FAIL wide_random M=%h Q=%h got %h exp %h tmo=%b", rm, rq, aq8, exp_p, tmo);
         end
         tick();
      end
   endtask

   task automatic test_signed();
      int lat;
      bit tmo;
      run4(4'b1101, 4'd7, lat, tmo);
      checks++;
      if ({tmo, aq4} !== {1'b0, 8'hEB} || lat != 4) begin
         errors++;
         $display("FAIL signed_neg3x7 got aq=%h lat=%0d exp EB 4", aq4, lat);
      end
      tick();
      run4(4'b1000, 4'b1000, lat, tmo);
      checks++;
      if ({tmo, aq4} !== {1'b0, 8'h40}) begin
         errors++;
         $display("FAIL signed_min_sq got aq=%h exp 40", aq4);
      end
      tick();
      run4(4'd5, 4'b1111, lat, tmo);
      checks++;
      if ({tmo, aq4} !== {1'b0, 8'hFB}) begin
         errors++;
         $display("FAIL signed_5xneg1 got aq=%h exp FB", aq4);
      end
      tick();
      run4(4'd7, 4'b1000, lat, tmo);
      checks++;
      if ({tmo, aq4} !== {1'b0, 8'hC8}) begin
         errors++;
         $display("FAIL signed_7xneg8 got aq=%h exp C8", aq4);
      end
      tick();
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst    = 1'b1;
      start4 = 1'b0;
      start8 = 1'b0;
      m4     = '0;
      q4     = '0;
      m8     = '0;
      q8     = '0;
      #1;
      test_reset();
      test_basic();
`ifdef SIGNED_MULT_EN
      test_signed();
`else
      test_extremes();
`endif
      test_ignore_start();
      test_back_to_back();
      test_reset_mid();
      test_wide();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
